// File: rtl/bcd_cmp_pkg.sv
// Shared definitions for the sequential BCD magnitude comparator:
// digit width, FSM state encoding and comparison result encoding.
package bcd_cmp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LT = 2'd0,
        EQ = 2'd1,
        GT = 2'd2
    } cmp_res_t;

    // One-hot {lt, eq, gt} view of a result code.
    function automatic logic [2:0] res_to_flags(input cmp_res_t r);
        logic [2:0] f;
        case (r)
            LT:      f = 3'b100;
            EQ:      f = 3'b010;
            GT:      f = 3'b001;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// Combinational unsigned compare of one 4-bit digit. Values above 9 are
// ordered as plain binary so a result is always produced.
module bcd_digit_cmp
    import bcd_cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               lt,
    output logic               eq,
    output logic               gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/bcd_mag_compare_seq.sv
// Sequential multi-digit BCD magnitude comparator. Latches both operands on
// start, then scans one digit per clock from the most significant digit and
// stops at the first difference. Results are registered and held until the
// next done pulse.
// Optional build macro BCD_CMP_CHECK_EN: flags any non-BCD digit (>9) seen in
// the operands at the start edge on the invalid output; otherwise invalid=0.
module bcd_mag_compare_seq
    import bcd_cmp_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] x,
    input  logic [DIGIT_W*DIGITS-1:0] y,
    output logic                      busy,
    output logic                      done,
    output logic                      lt,
    output logic                      eq,
    output logic                      gt,
    output logic                      invalid
);

    localparam int OP_W  = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OP_W-1:0]    r_x;
    logic [OP_W-1:0]    r_y;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic               r_lt;
    logic               r_eq;
    logic               r_gt;

    logic [OP_W-1:0]    w_shx;
    logic [OP_W-1:0]    w_shy;
    logic [DIGIT_W-1:0] w_dig_x;
    logic [DIGIT_W-1:0] w_dig_y;
    logic               w_dlt;
    logic               w_deq;
    logic               w_dgt;
    logic               w_load;
    logic               w_resolve;
    logic               w_idx_dec;
    cmp_res_t           w_res;
    logic [2:0]         w_flags;

    // Digit mux: bring digit r_idx of each latched operand down to bits [3:0].
    assign w_shx   = r_x >> (r_idx * DIGIT_W);
    assign w_shy   = r_y >> (r_idx * DIGIT_W);
    assign w_dig_x = w_shx[DIGIT_W-1:0];
    assign w_dig_y = w_shy[DIGIT_W-1:0];

    bcd_digit_cmp u_digit_cmp (
        .a  (w_dig_x),
        .b  (w_dig_y),
        .lt (w_dlt),
        .eq (w_deq),
        .gt (w_dgt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and per-cycle control: load on start, resolve on first
    // differing digit or after the last equal digit, else step down.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_resolve   = 1'b0;
        w_idx_dec   = 1'b0;
        w_res       = EQ;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_dlt) begin
                    w_res       = LT;
                    w_resolve   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_dgt) begin
                    w_res       = GT;
                    w_resolve   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_idx == '0) begin
                    w_res       = EQ;
                    w_resolve   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_dec   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_flags = res_to_flags(w_res);

    // Digit index: restart at the most significant digit on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_idx <= IDX_MAX;
        else if (w_load)    r_idx <= IDX_MAX;
        else if (w_idx_dec) r_idx <= r_idx - IDX_W'(1);
    end

    // Operand capture; later x/y changes cannot disturb a running scan.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_x <= x;
            r_y <= y;
        end
    end

    // Result flags and done pulse; flags are only rewritten on resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
        end else begin
            r_done <= w_resolve;
            if (w_resolve) begin
                r_lt <= w_flags[2];
                r_eq <= w_flags[1];
                r_gt <= w_flags[0];
            end
        end
    end

`ifdef BCD_CMP_CHECK_EN
    logic r_inv_pend;
    logic r_invalid;

    function automatic logic any_non_bcd(input logic [OP_W-1:0] v);
        logic f;
        f = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) f = 1'b1;
        end
        return f;
    endfunction

    // Non-BCD check is taken on the raw operands at the start edge and
    // only published alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv_pend <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            if (w_load)    r_inv_pend <= any_non_bcd(x) | any_non_bcd(y);
            if (w_resolve) r_invalid  <= r_inv_pend;
        end
    end

    assign invalid = r_invalid;
`else
    assign invalid = 1'b0;
`endif

    assign busy = (r_state == SCAN);
    assign done = r_done;
    assign lt   = r_lt;
    assign eq   = r_eq;
    assign gt   = r_gt;

endmodule

// File: tb/tb_bcd_mag_compare_seq.sv
// Directed, table-driven bench for bcd_mag_compare_seq (DIGITS=4 instance plus
// a DIGITS=1 instance), with hand-written sequences for restart, back-to-back
// start and mid-scan reset.
module tb_bcd_mag_compare_seq;

    localparam int DIGITS = 4;
`ifdef BCD_CMP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] y;
        logic        lt;
        logic        eq;
        logic        gt;
        logic        nonbcd;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        busy, done, lt, eq, gt, invalid;

    logic        start1 = 1'b0;
    logic [3:0]  x1 = '0;
    logic [3:0]  y1 = '0;
    logic        busy1, done1, lt1, eq1, gt1, invalid1;

    int n_chk  = 0;
    int n_fail = 0;
    logic p_lt = 1'b0, p_eq = 1'b0, p_gt = 1'b0;

    vec_t vecs[10];

    always #5 clk = ~clk;

    bcd_mag_compare_seq #(.DIGITS(DIGITS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .invalid(invalid)
    );

    bcd_mag_compare_seq #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1), .invalid(invalid1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        x = v.x; y = v.y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, " flags held at start"}, {29'd0, lt, eq, gt}, {29'd0, p_lt, p_eq, p_gt});
        x = ~v.x; y = v.x;
        seen = 1'b0; lat = 0; bcnt = 0;
        for (int c = 1; c <= DIGITS + 4 && !seen; c++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " busy cycles"}, bcnt, v.lat);
        chk({v.name, " lt/eq/gt"}, {29'd0, lt, eq, gt}, {29'd0, v.lt, v.eq, v.gt});
        chk({v.name, " invalid"}, {31'd0, invalid}, {31'd0, v.nonbcd & CHK});
        chk({v.name, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk({v.name, " done one cycle"}, {31'd0, done}, 32'd0);
        chk({v.name, " flags hold"}, {29'd0, lt, eq, gt}, {29'd0, v.lt, v.eq, v.gt});
        p_lt = v.lt; p_eq = v.eq; p_gt = v.gt;
    endtask

    task automatic run1(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic elt, input logic eeq, input logic egt);
        @(negedge clk);
        x1 = a; y1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk({nm, " busy"}, {31'd0, busy1}, 32'd1);
        @(posedge clk); #1;
        chk({nm, " done"}, {31'd0, done1}, 32'd1);
        chk({nm, " flags"}, {29'd0, lt1, eq1, gt1}, {29'd0, elt, eeq, egt});
        chk({nm, " idle"}, {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        int dcnt;
        int dlat;
        bit seen;

        vecs[0] = '{"eq 1234",      16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{"gt 5000/4999", 16'h5000, 16'h4999, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2] = '{"lt 1239/1240", 16'h1239, 16'h1240, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[3] = '{"lt 0007/0008", 16'h0007, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[4] = '{"eq 0000",      16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{"gt 9999/0000", 16'h9999, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{"gt 0001/0000", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[7] = '{"gt 12A4/1204", 16'h12A4, 16'h1204, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        vecs[8] = '{"lt 1234/123F", 16'h1234, 16'h123F, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[9] = '{"gt F000/9000", 16'hF000, 16'h9000, 1'b0, 1'b0, 1'b1, 1'b1, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {26'd0, busy, done, lt, eq, gt, invalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven comparisons
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Restart pulse during a scan is ignored
        @(negedge clk);
        x = 16'h1111; y = 16'h1112; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0; dlat = 0;
        for (int c = 1; c <= 8; c++) begin
            start = (c == 2);
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (dlat == 0) dlat = c;
            end
        end
        start = 1'b0;
        chk("restart ignored done count", dcnt, 1);
        chk("restart ignored latency", dlat, 4);
        chk("restart ignored result", {29'd0, lt, eq, gt}, 32'b100);

        // Start held during done is accepted as a new comparison
        @(negedge clk);
        x = 16'h1111; y = 16'h1112; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("b2b first done", {31'd0, seen}, 32'd1);
        chk("b2b first result", {29'd0, lt, eq, gt}, 32'b100);
        x = 16'h5000; y = 16'h4999; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b second accepted", {30'd0, busy, done}, 32'b10);
        @(posedge clk); #1;
        chk("b2b second done", {31'd0, done}, 32'd1);
        chk("b2b second result", {29'd0, lt, eq, gt}, 32'b001);
        p_lt = 1'b0; p_eq = 1'b0; p_gt = 1'b1;

        // Reset mid-scan aborts with no done
        @(negedge clk);
        x = 16'h1234; y = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid-scan reset outputs", {26'd0, busy, done, lt, eq, gt, invalid}, 32'd0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("mid-scan reset no done", dcnt, 0);
        @(negedge clk);
        rst = 1'b0;
        p_lt = 1'b0; p_eq = 1'b0; p_gt = 1'b0;
        run_vec(vecs[0]);

        // Single-digit instance resolves every compare in one cycle
        run1("d1 gt 7/3", 4'd7, 4'd3, 1'b0, 1'b0, 1'b1);
        run1("d1 eq 5/5", 4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
        run1("d1 lt 2/9", 4'd2, 4'd9, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
